// File: rtl/mac_share_scheduler.sv
// mac_share_scheduler: round-robin time-sharing of one MAC engine between N
// filter stages, sequencing tap index and first/last flags per granted job.
`default_nettype none

module mac_share_scheduler #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*CW-1:0] len,
    input  logic            clr_ovr,
    output logic [N-1:0]    grant,
    output logic            busy,
    output logic [CW-1:0]   tap_idx,
    output logic            first,
    output logic            last,
    output logic [N-1:0]    done,
    output logic [N-1:0]    overrun
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0] ONE = N'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [N-1:0]    pending;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [CW-1:0]   tap_max;

    logic [PW-1:0]   win;
    logic            win_vld;
    logic [N-1:0]    win_oh;
    logic [N-1:0]    take;
    logic [CW-1:0]   win_len;

    // Scan downward so the candidate closest to the pointer is assigned last.
    always_comb begin
        logic [PW-1:0] idx;
        win     = ptr;
        win_vld = 1'b0;
        idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % N);
            if (pending[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    assign win_oh  = ONE << win;
    assign take    = (state != RUN && win_vld) ? win_oh : '0;
    assign win_len = len[int'(win)*CW +: CW];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pending <= '0;
            overrun <= '0;
            ptr     <= '0;
            owner   <= '0;
            tap_max <= '0;
            grant   <= '0;
            busy    <= 1'b0;
            tap_idx <= '0;
            first   <= 1'b0;
            last    <= 1'b0;
            done    <= '0;
        end else begin
            // A request landing on its own grant edge re-queues rather than overruns.
            pending <= (pending & ~take) | req;
            overrun <= (overrun & ~{N{clr_ovr}}) | (req & pending & ~take);

            case (state)
                IDLE, DONE: begin
                    done <= '0;
                    if (win_vld) begin
                        state   <= RUN;
                        grant   <= win_oh;
                        owner   <= win;
                        busy    <= 1'b1;
                        tap_idx <= '0;
                        first   <= 1'b1;
                        last    <= (win_len <= CW'(1));
                        tap_max <= (win_len == '0) ? '0 : win_len - 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (last) begin
                        state   <= DONE;
                        grant   <= '0;
                        busy    <= 1'b0;
                        first   <= 1'b0;
                        last    <= 1'b0;
                        tap_idx <= '0;
                        done    <= grant;
                        ptr     <= (owner == PW'(N - 1)) ? '0 : owner + 1'b1;
                    end else begin
                        tap_idx <= tap_idx + 1'b1;
                        first   <= 1'b0;
                        last    <= ((tap_idx + 1'b1) == tap_max);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mac_share_scheduler.sv
// tb_mac_share_scheduler: directed and random stimulus against a job-level
// reference model of the round-robin MAC scheduler.
`default_nettype none

module tb_mac_share_scheduler;

    localparam int N  = 4;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*CW-1:0] len = '0;
    logic            clr_ovr = 1'b0;
    logic [N-1:0]    grant;
    logic            busy;
    logic [CW-1:0]   tap_idx;
    logic            first;
    logic            last;
    logic [N-1:0]    done;
    logic [N-1:0]    overrun;

    mac_share_scheduler #(.N(N), .CW(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .len     (len),
        .clr_ovr (clr_ovr),
        .grant   (grant),
        .busy    (busy),
        .tap_idx (tap_idx),
        .first   (first),
        .last    (last),
        .done    (done),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: job-level view of the scheduler.
    bit          m_run;
    bit          m_dph;
    int          m_own, m_tap, m_L, m_dow, m_ptr;
    bit [N-1:0]  m_pend;
    bit [N-1:0]  m_ovr;

    task automatic model_reset();
        m_run = 0; m_dph = 0; m_own = 0; m_tap = 0; m_L = 1; m_dow = 0; m_ptr = 0;
        m_pend = '0; m_ovr = '0;
    endtask

    task automatic model_step();
        int w;
        int j;
        bit [N-1:0] gv;
        w = -1;
        if (!m_run)
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (m_pend[j] && w < 0) w = j;
            end
        gv = (w >= 0) ? N'(1 << w) : '0;
        m_ovr  = (clr_ovr ? '0 : m_ovr) | (req & m_pend & ~gv);
        m_pend = (m_pend & ~gv) | req;
        m_dph  = 0;
        if (m_run) begin
            if (m_tap == m_L - 1) begin
                m_run = 0; m_dph = 1; m_dow = m_own; m_ptr = (m_own + 1) % N;
            end else begin
                m_tap++;
            end
        end else if (w >= 0) begin
            m_run = 1; m_own = w; m_tap = 0;
            m_L = int'(len[w*CW +: CW]);
            if (m_L == 0) m_L = 1;
        end
    endtask

    task automatic check_outputs();
        check("grant",   32'(grant),   m_run ? 32'(1 << m_own) : 32'd0);
        check("busy",    32'(busy),    32'(m_run));
        check("tap_idx", 32'(tap_idx), m_run ? 32'(m_tap) : 32'd0);
        check("first",   32'(first),   32'(m_run && m_tap == 0));
        check("last",    32'(last),    32'(m_run && m_tap == m_L - 1));
        check("done",    32'(done),    m_dph ? 32'(1 << m_dow) : 32'd0);
        check("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic cyc(input logic [N-1:0] r, input logic c);
        req = r; clr_ovr = c;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
        req = '0; clr_ovr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc('0, 1'b0);
    endtask

    task automatic set_len(input int s, input int v);
        len[s*CW +: CW] = CW'(v);
    endtask

    initial begin
        model_reset();
        #12;
        check_outputs();
        check("reset_grant", 32'(grant), 32'd0);
        rst = 1'b1;

        // Single 5-tap job on stage 2
        set_len(2, 5);
        cyc(4'b0100, 1'b0);
        check("req_edge_no_grant", 32'(grant), 32'd0);
        cyc('0, 1'b0);
        check("single_grant", 32'(grant), 32'b0100);
        idle(7);

        // All stages at once, 3 taps each
        for (int s = 0; s < N; s++) set_len(s, 3);
        cyc(4'b1111, 1'b0);
        idle(18);

        // Stage 1 served, then 0 and 3 pending: 3 must win
        set_len(1, 2);
        cyc(4'b0010, 1'b0);
        cyc(4'b1001, 1'b0);
        idle(3);
        check("ptr_order", 32'(grant), 32'b1000);
        idle(10);

        // Duplicate request while pending -> overrun, then clear
        set_len(0, 10);
        cyc(4'b0001, 1'b0);
        cyc('0, 1'b0);
        cyc(4'b0010, 1'b0);
        cyc('0, 1'b0);
        cyc(4'b0010, 1'b0);
        check("overrun_set", 32'(overrun), 32'b0010);
        idle(20);
        cyc('0, 1'b1);
        check("overrun_clr", 32'(overrun), 32'd0);

        // Request on its own grant edge, zero-length job
        set_len(0, 0);
        cyc(4'b0001, 1'b0);
        cyc(4'b0001, 1'b0);
        check("len0_first_last", 32'({first, last}), 32'b11);
        idle(6);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0)
                set_len($urandom_range(0, N - 1), $urandom_range(0, 6));
            cyc(N'($urandom & $urandom & $urandom), ($urandom_range(0, 19) == 0));
        end
        idle(40);

        // Asynchronous reset mid-job
        set_len(2, 8);
        cyc(4'b0100, 1'b0);
        idle(4);
        check("mid_run_tap", 32'(tap_idx), 32'd3);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        set_len(1, 2); set_len(3, 2);
        cyc(4'b1010, 1'b0);
        cyc('0, 1'b0);
        check("post_reset_lowest", 32'(grant), 32'b0010);
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mac_share_scheduler.md
Name: mac_share_scheduler

Overview:
- Round-robin scheduler that time-shares one multiply-accumulate engine between up to N filter stages of a sample-rate-converter chain (e.g. the 882/1764/3528 kHz interpolation FIRs and the 3360 kHz decimation FIR).
- Each stage raises a one-cycle request on its sample-enable strobe. The scheduler queues it, grants the MAC for that stage's tap count, and drives the tap index and first/last flags that sequence the MAC and coefficient ROM.
- Sticky per-stage overrun flags report requests that arrive before the previous one was served.

Parameters:
- N, 4, number of requesting stages (2..8).
- CW, 8, width of tap-count and tap-index fields (jobs up to 2^CW-1 taps).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  N  per-stage one-cycle request strobe (stage sample enable).
- len  in  N*CW  per-stage tap count; stage i uses bits [i*CW +: CW].
- clr_ovr  in  1  synchronous clear of all overrun flags.
- grant  out  N  one-hot; the stage owning the MAC this cycle.
- busy  out  1  high while a job is in RUN.
- tap_idx  out  CW  current tap index within the job.
- first  out  1  high on the tap_idx==0 cycle; MAC clears its accumulator.
- last  out  1  high on the final tap cycle.
- done  out  N  one-cycle pulse for the stage whose job just finished.
- overrun  out  N  sticky per-stage overrun flags.

Behaviour:
- Reset (rst low, asynchronous): state IDLE. pending, grant, done and overrun are 0. busy, first and last are 0. tap_idx is 0. Round-robin pointer is 0, so stage 0 has top priority.
- pending[i]: set at the clock edge where req[i]=1; cleared at the edge where stage i is granted.
- Same-edge set and clear: if req[i] coincides with the grant of i, pending[i] ends at 1 and no overrun is flagged.
- overrun[i]: set when req[i]=1 while pending[i] is already 1 and not being granted that edge. The duplicate is dropped, not double-queued. A req during stage i's own RUN is legal and simply re-queues.
- Overrun clear: clr_ovr clears all overrun bits. If clr_ovr coincides with a new overrun event, set wins.
- FSM has three states: IDLE, RUN, DONE.
- IDLE: if pending != 0, pick a winner and go to RUN.
  - Winner is the first set pending bit at or after the pointer, scanning upward modulo N.
  - On entry to RUN: grant <= onehot(winner), tap_idx <= 0, first <= 1.
  - len[winner] is latched as L; L==0 is treated as 1.
- RUN: grant is held and busy=1. tap_idx increments by 1 each cycle. last=1 when tap_idx==L-1. After the last cycle, go to DONE.
- DONE (1 cycle): grant=0, busy=0, done[g]=1 for the finished stage. The pointer advances to g+1 mod N. The next winner is arbitrated in this cycle: go to RUN if pending != 0, else IDLE.
- Latency: req at edge t gives pending at t. The grant/first cycle starts at edge t+1 if idle. Back-to-back jobs cost L+1 cycles each.
- len changes after the grant have no effect on the running job.
- first and last are both 1 in the same cycle when L==1.

Test Plan:
- Reset, then a single req[2] with len2=5 -> grant=0100 one cycle after the req edge. tap_idx runs 0..4, with first at 0 and last at 4. Next cycle done=0100, then IDLE.
- req on all 4 stages in the same cycle, each with len=3 -> grants in order 0,1,2,3. Each job is 3 RUN + 1 DONE cycles (16 cycles total). No overrun.
- Pointer at 2 (stage 1 just served); pending on stages 0 and 3 -> stage 3 is granted before stage 0.
- req[1] twice while stage 0 runs a 10-tap job -> overrun=0010 is set, and stage 1 is served once. clr_ovr -> overrun=0000.
- req[0] on the same edge its grant is issued -> pending[0] stays 1, and stage 0 is re-served after the job with no overrun. len0=0 -> single-cycle job with first=last=1.
- rst asserted mid-RUN at tap_idx=3 -> all outputs 0 immediately without a clock edge. After release, the first grant goes to the lowest pending stage; pending is empty after reset.
